// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the instruction fetch stage: PC-source select values,
// special instruction words and fetch FSM states.
package instruction_fetch_pkg;

  localparam logic [1:0] PcSeq     = 2'b00;
  localparam logic [1:0] PcBranch  = 2'b01;
  localparam logic [1:0] PcJump    = 2'b10;
  localparam logic [1:0] PcJumpReg = 2'b11;

  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;
  localparam logic [31:0] NopWord  = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded program survives a core reset.
module instruction_memory #(
  parameter int NB_DATA        = 32,
  parameter int NB_MEM_ADDRESS = 8
) (
  input  logic                      clock,
  input  logic                      write_enable,
  input  logic [NB_MEM_ADDRESS-1:0] write_address,
  input  logic [NB_DATA-1:0]        write_data,
  input  logic [NB_MEM_ADDRESS-1:0] read_address,
  output logic [NB_DATA-1:0]        read_data
);

  logic [NB_DATA-1:0] mem [2**NB_MEM_ADDRESS];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with program-load port, IDLE/RUN/HALT control and
// branch/jump redirection without a delay slot (redirects squash to NOP).
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA         = 32,
  parameter int NB_JUMP_ADDRESS = 26,
  parameter int NB_MEM_ADDRESS  = 8,
  parameter int NB_PC_SOURCE    = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_enable,
  input  logic                       i_stall,
  input  logic [NB_PC_SOURCE-1:0]    i_pc_source,
  input  logic [NB_DATA-1:0]         i_branch_offset,
  input  logic [NB_JUMP_ADDRESS-1:0] i_jump_address,
  input  logic [NB_DATA-1:0]         i_jump_register_data,
  input  logic                       i_prog_write_enable,
  input  logic [NB_MEM_ADDRESS-1:0]  i_prog_write_address,
  input  logic [NB_DATA-1:0]         i_prog_write_data,
  output logic [NB_DATA-1:0]         o_instruction,
  output logic [NB_DATA-1:0]         o_next_pc,
  output logic [NB_DATA-1:0]         o_pc,
  output logic                       o_halt,
  output logic                       o_running
);

  state_e             state_q;
  logic [NB_DATA-1:0] pc_q;
  logic [NB_DATA-1:0] instr_q;
  logic [NB_DATA-1:0] next_pc_q;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] target;
  logic [NB_DATA-1:0] fetch_word;
  logic               redirect;
  logic               mem_we;

  // Loading is only allowed while idle, but a strobe coincident with reset always lands.
  assign mem_we = i_prog_write_enable & (i_reset | ((state_q == StIdle) & i_enable));

  instruction_memory #(
    .NB_DATA        (NB_DATA),
    .NB_MEM_ADDRESS (NB_MEM_ADDRESS)
  ) u_instruction_memory (
    .clock         (i_clock),
    .write_enable  (mem_we),
    .write_address (i_prog_write_address),
    .write_data    (i_prog_write_data),
    .read_address  (pc_q[NB_MEM_ADDRESS+1:2]),
    .read_data     (fetch_word)
  );

  assign pc_plus4 = pc_q + NB_DATA'(4);
  assign redirect = (i_pc_source != PcSeq);

  // Branch and jump targets are relative to the instruction sitting in IF/ID.
  always_comb begin
    target = pc_plus4;
    case (i_pc_source)
      PcBranch:  target = next_pc_q + (i_branch_offset << 2);
      PcJump:    target = {next_pc_q[NB_DATA-1:NB_JUMP_ADDRESS+2], i_jump_address, 2'b00};
      PcJumpReg: target = i_jump_register_data;
      default:   target = pc_plus4;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instr_q   <= NB_DATA'(NopWord);
      next_pc_q <= '0;
    end else if (i_enable) begin
      case (state_q)
        StIdle: begin
          pc_q      <= '0;
          instr_q   <= NB_DATA'(NopWord);
          next_pc_q <= '0;
          if (i_start) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!i_stall) begin
            next_pc_q <= pc_plus4;
            if (redirect) begin
              // A redirect beats a fetched HALT word: squash it and follow the target.
              instr_q <= NB_DATA'(NopWord);
              pc_q    <= target;
            end else begin
              instr_q <= fetch_word;
              if (fetch_word == NB_DATA'(HaltWord)) begin
                state_q <= StHalt;
              end else begin
                pc_q <= pc_plus4;
              end
            end
          end
        end
        StHalt: begin
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_instruction = instr_q;
  assign o_next_pc     = next_pc_q;
  assign o_pc          = pc_q;
  assign o_halt        = (state_q == StHalt);
  assign o_running     = (state_q == StRun);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch against a behavioural fetch model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset, start, enable, stall;
  logic [1:0]  pc_source;
  logic [31:0] branch_offset, jump_register_data, prog_write_data;
  logic [25:0] jump_address;
  logic        prog_write_enable;
  logic [7:0]  prog_write_address;
  logic [31:0] instruction, next_pc, pc;
  logic        halt, running;

  always #5 clock = ~clock;

  instruction_fetch #(
    .NB_DATA         (32),
    .NB_JUMP_ADDRESS (26),
    .NB_MEM_ADDRESS  (8),
    .NB_PC_SOURCE    (2)
  ) dut (
    .i_clock              (clock),
    .i_reset              (reset),
    .i_start              (start),
    .i_enable             (enable),
    .i_stall              (stall),
    .i_pc_source          (pc_source),
    .i_branch_offset      (branch_offset),
    .i_jump_address       (jump_address),
    .i_jump_register_data (jump_register_data),
    .i_prog_write_enable  (prog_write_enable),
    .i_prog_write_address (prog_write_address),
    .i_prog_write_data    (prog_write_data),
    .o_instruction        (instruction),
    .o_next_pc            (next_pc),
    .o_pc                 (pc),
    .o_halt               (halt),
    .o_running            (running)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: 0 idle, 1 run, 2 halt.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_ir, m_npc;
  int          m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic defaults();
    reset = 0; start = 0; enable = 1; stall = 0; pc_source = 2'b00;
    branch_offset = 0; jump_address = 0; jump_register_data = 0;
    prog_write_enable = 0; prog_write_address = 0; prog_write_data = 0;
  endtask

  // Advance one clock: predict from the spec rules, then compare all outputs.
  task automatic tick();
    logic [31:0] n_pc, n_ir, n_npc, word;
    int n_st;
    bit  wr;
    n_pc = m_pc; n_ir = m_ir; n_npc = m_npc; n_st = m_st;
    word = m_mem[m_pc[9:2]];
    wr = prog_write_enable && (reset || (m_st == 0 && enable));
    if (reset) begin
      n_st = 0; n_pc = 0; n_ir = 0; n_npc = 0;
    end else if (enable) begin
      if (m_st == 0 && start) n_st = 1;
      else if (m_st == 1 && !stall) begin
        n_npc = m_pc + 4;
        if (pc_source == 2'd0) begin
          n_ir = word;
          if (word == 32'hFFFF_FFFF) n_st = 2;
          else n_pc = m_pc + 4;
        end else begin
          n_ir = 0;
          if (pc_source == 2'd1) n_pc = m_npc + branch_offset * 4;
          else if (pc_source == 2'd2) n_pc = (m_npc & 32'hF000_0000) | ({6'd0, jump_address} * 4);
          else n_pc = jump_register_data;
        end
      end
    end
    if (wr) m_mem[prog_write_address] = prog_write_data;
    @(posedge clock);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_npc = n_npc; m_st = n_st;
    chk("pc", pc, m_pc);
    chk("instruction", instruction, m_ir);
    chk("next_pc", next_pc, m_npc);
    chk("halt", {31'd0, halt}, {31'd0, m_st == 2});
    chk("running", {31'd0, running}, {31'd0, m_st == 1});
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    prog_write_enable = 1; prog_write_address = a; prog_write_data = d;
    tick();
    prog_write_enable = 0;
  endtask

  initial begin
    int r;
    defaults();
    m_pc = 0; m_ir = 0; m_npc = 0; m_st = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 0;

    // Reset into IDLE
    reset = 1; tick(); tick(); reset = 0;
    chk("reset_pc", pc, 32'h0);
    chk("reset_instr", instruction, 32'h0);

    // Background fill and three-instruction program
    for (int i = 0; i < 256; i++) write_word(8'(i), 32'h1000_0000 + i);
    write_word(8'd0, 32'h2001_0005);
    write_word(8'd1, 32'h2002_0003);
    write_word(8'd2, 32'hFFFF_FFFF);

    start = 1; tick(); start = 0;
    chk("started", {31'd0, running}, 32'd1);
    tick(); chk("seq0", instruction, 32'h2001_0005);
    tick(); chk("seq1", instruction, 32'h2002_0003);
    tick(); chk("seq2", instruction, 32'hFFFF_FFFF);
    chk("halt_flag", {31'd0, halt}, 32'd1);
    chk("halt_pc", pc, 32'h8);
    tick(); tick();
    chk("halt_frozen_pc", pc, 32'h8);

    // Reset in HALT, restart from retained program
    reset = 1; tick(); reset = 0;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_ir", instruction, 32'h0);
    start = 1; tick(); start = 0;
    tick(); chk("rerun0", instruction, 32'h2001_0005);
    tick(); chk("rerun_npc", next_pc, 32'h8);

    // Backward branch to 0
    pc_source = 2'b01; branch_offset = 32'hFFFF_FFFE; tick();
    chk("branch_nop", instruction, 32'h0);
    chk("branch_pc", pc, 32'h0);
    pc_source = 2'b10; jump_address = 26'h10; tick();
    chk("jump_pc", pc, 32'h40);
    chk("jump_nop", instruction, 32'h0);
    pc_source = 2'b11; jump_register_data = 32'h20; tick();
    chk("jr_pc", pc, 32'h20);
    chk("jr_nop", instruction, 32'h0);

    // Stall outranks redirect
    stall = 1; pc_source = 2'b01; branch_offset = 32'h10;
    tick(); tick(); tick();
    chk("stall_pc", pc, 32'h20);
    stall = 0; pc_source = 2'b00; tick();
    chk("stall_release", instruction, 32'h1000_0008);
    chk("stall_release_pc", pc, 32'h24);

    // Freeze, with a write attempt in RUN
    enable = 0; write_word(8'd0, 32'hDEAD_BEEF); tick(); enable = 1;
    chk("freeze_pc", pc, 32'h24);

    // Redirect onto the HALT word squashes it
    pc_source = 2'b11; jump_register_data = 32'h8; tick();
    pc_source = 2'b11; jump_register_data = 32'h0; tick();
    chk("redirect_over_halt", {31'd0, halt}, 32'd0);
    chk("redirect_over_halt_ir", instruction, 32'h0);
    pc_source = 2'b00;

    // Word 0 retained, then write coincident with start
    reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0; tick();
    chk("mem0_retained", instruction, 32'h2001_0005);
    reset = 1; tick(); reset = 0;
    start = 1; prog_write_enable = 1; prog_write_address = 0; prog_write_data = 32'h2003_0007;
    tick();
    start = 0; prog_write_enable = 0;
    tick();
    chk("write_with_start", instruction, 32'h2003_0007);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(99) < 3);
      enable = ($urandom_range(9) != 0);
      start = ($urandom_range(3) == 0);
      stall = ($urandom_range(4) == 0);
      r = $urandom_range(9);
      pc_source = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
      branch_offset = 32'($urandom_range(15)) - 32'd8;
      jump_address = 26'($urandom_range(255));
      jump_register_data = 32'($urandom_range(1023));
      prog_write_enable = ($urandom_range(3) == 0);
      prog_write_address = 8'($urandom_range(255));
      prog_write_data = ($urandom_range(9) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
